// File: rtl/nios_dbg_jtag_host_pkg.sv
// Shared types and defaults for the Nios II debug virtual-JTAG host.
package nios_dbg_jtag_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        RESP
    } state_e;

    localparam int DR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;

    // The SDR bit counter must be able to hold the value DR_WIDTH.
    localparam int BITCNT_W_DEF = $clog2(DR_WIDTH_DEF + 1);

    function automatic int bitcnt_w(input int dr_w);
        return $clog2(dr_w + 1);
    endfunction

endpackage

// File: rtl/nios_dbg_tck_gen.sv
// TCK phase generator: vji_tck level plus one-clk rise/fall strobes.
// NIOS_DBG_JTAG_HOST_FREERUN_TCK_EN keeps the phase counter running outside a scan.
module nios_dbg_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic clr_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o,
    output logic last_o
);
    localparam int PH_W = $clog2(2 * TCK_DIV);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(TCK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HI   = PH_W'(TCK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * TCK_DIV - 1);

    logic [PH_W-1:0] ph_q, ph_d;
    logic            cnt_en;

`ifdef NIOS_DBG_JTAG_HOST_FREERUN_TCK_EN
    assign cnt_en = 1'b1;
`else
    assign cnt_en = run_i;
`endif

    always_comb begin
        ph_d = ph_q;
        if (clr_i || !cnt_en)   ph_d = '0;
        else if (ph_q == PH_LAST) ph_d = '0;
        else                    ph_d = ph_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ph_q <= '0;
        else       ph_q <= ph_d;
    end

    // Strobes only matter to the scan FSM, so they are gated by run_i in both builds.
    assign tck_o  = (ph_q >= PH_HI);
    assign rise_o = run_i && !clr_i && (ph_q == PH_RISE);
    assign fall_o = run_i && !clr_i && (ph_q == PH_LAST);
    assign last_o = (ph_q == PH_LAST);

endmodule

// File: rtl/nios_dbg_jtag_host.sv
// Virtual-JTAG initiator: one IR+DR scan per command, UIR/CDR/SDR*N/UDR strobes.
// NIOS_DBG_JTAG_HOST_FREERUN_TCK_EN selects free-running TCK with phase-aligned accept.
module nios_dbg_jtag_host
    import nios_dbg_jtag_host_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                busy
);
    localparam int CNT_W = bitcnt_w(DR_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_WIDTH - 1);

    state_e              state_q, state_d;
    logic [DR_WIDTH-1:0] tx_q, tx_d;
    logic [DR_WIDTH-1:0] cap_q, cap_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic run, accept, rise, fall, ph_last;

    assign run    = (state_q == UIR) || (state_q == CDR) || (state_q == SDR) || (state_q == UDR);
    assign accept = cmd_valid && cmd_ready;

    nios_dbg_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
        .clk    (clk),
        .reset  (reset),
        .run_i  (run),
        .clr_i  (accept),
        .tck_o  (vji_tck),
        .rise_o (rise),
        .fall_o (fall),
        .last_o (ph_last)
    );

`ifdef NIOS_DBG_JTAG_HOST_FREERUN_TCK_EN
    assign cmd_ready = (state_q == IDLE) && ph_last;
`else
    assign cmd_ready = (state_q == IDLE);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = UIR;
            UIR:     if (fall) state_d = CDR;
            CDR:     if (fall) state_d = SDR;
            SDR:     if (fall && cnt_q == CNT_LAST) state_d = UDR;
            UDR:     if (fall) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d     = tx_q;
        cap_d    = cap_q;
        rsp_dr_d = rsp_dr_q;
        rsp_ir_d = rsp_ir_q;
        ir_in_d  = ir_in_q;
        cnt_d    = cnt_q;
        if (accept) begin
            tx_d    = cmd_dr;
            ir_in_d = cmd_ir;
        end
        if (state_q == CDR) begin
            cnt_d = '0;
            if (rise) rsp_ir_d = vji_ir_out;
        end
        // TDO is sampled on TCK rise, TDI advances on TCK fall.
        if (state_q == SDR) begin
            if (rise) cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
            if (fall) begin
                tx_d  = {1'b0, tx_q[DR_WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (state_q == UDR && fall) rsp_dr_d = cap_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tx_q     <= '0;
            cap_q    <= '0;
            rsp_dr_q <= '0;
            rsp_ir_q <= '0;
            ir_in_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            cap_q    <= cap_d;
            rsp_dr_q <= rsp_dr_d;
            rsp_ir_q <= rsp_ir_d;
            ir_in_q  <= ir_in_d;
            cnt_q    <= cnt_d;
        end
    end

    assign vji_rti   = (state_q == IDLE) || (state_q == RESP);
    assign vji_uir   = (state_q == UIR);
    assign vji_cdr   = (state_q == CDR);
    assign vji_sdr   = (state_q == SDR);
    assign vji_udr   = (state_q == UDR);
    assign vji_tdi   = (state_q == SDR) && tx_q[0];
    assign vji_ir_in = ir_in_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_dr    = rsp_dr_q;
    assign rsp_ir    = rsp_ir_q;
    assign busy      = (state_q != IDLE);

endmodule
